frecuenciometro_ctrl: RTL and testbench

FRECUENCIOMETRO_CTRL -- requirements
Module: frecuenciometro_ctrl

---
 rtl/frecuenciometro_pkg.sv | 17 +
 rtl/frecuenciometro_gate_timer.sv | 30 +++
 rtl/frecuenciometro_ctrl.sv | 96 +++++++++
 tb/tb_frecuenciometro_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frecuenciometro_pkg.sv
// frecuenciometro_pkg: shared FSM states, range codes and limits for the frequency meter controller
package frecuenciometro_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;

    localparam logic [1:0] R_1S = 2'd0;
    localparam logic [1:0] R_100MS = 2'd1;
    localparam logic [1:0] R_10MS = 2'd2;

    localparam logic [19:0] FREQ_MAX = 20'd999_999;
    localparam logic [19:0] DOWN_LIM = 20'd100_000;

    function automatic int gate_cycles(input int base, input logic [1:0] r);
        return r == R_1S ? base * 100 : r == R_100MS ? base * 10 : base;
    endfunction

endpackage

// File: rtl/frecuenciometro_gate_timer.sv
// gate_timer: loadable down-counter; done is high in the last of load+1 cycles after start
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         act;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            act <= 1'b0;
        end else if (start) begin
            cnt <= load;
            act <= 1'b1;
        end else if (act) begin
            if (cnt == '0) act <= 1'b0;
            else cnt <= cnt - 1'b1;
        end
    end

    assign done = act && cnt == '0;

endmodule

// File: rtl/frecuenciometro_ctrl.sv
// frecuenciometro_ctrl: gate/latch/hold sequencer with autorange for an external edge counter
module frecuenciometro_ctrl
    import frecuenciometro_pkg::*;
#(
    parameter int GATE_BASE = 500_000,
    parameter int HOLD_CYC  = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        auto_en,
    input  logic [1:0]  range_sel,
    input  logic [19:0] cnt_val,
    input  logic        cnt_ovf,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic [19:0] freq,
    output logic [1:0]  dp_pos,
    output logic        freq_valid,
    output logic        over,
    output logic        busy
);

    localparam int TOP = GATE_BASE * 100 > HOLD_CYC ? GATE_BASE * 100 : HOLD_CYC;
    localparam int TW  = $clog2(TOP > 2 ? TOP : 2);

    state_t          state, nxt;
    logic [1:0]      r, sel;
    logic            ovf, up, down;
    logic            tmr_start, tmr_done;
    logic [TW-1:0]   tmr_load;

    always_comb begin
        sel = range_sel == 2'd3 ? R_10MS : range_sel;
        ovf = cnt_ovf || cnt_val > FREQ_MAX;
        up = ovf && auto_en && r < R_10MS;
        down = !ovf && auto_en && r != R_1S && cnt_val < DOWN_LIM;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = run ? CLEAR : IDLE;
            CLEAR:   nxt = run ? GATE : IDLE;
            GATE:    nxt = !run ? IDLE : tmr_done ? SETTLE : GATE;
            SETTLE:  nxt = !run ? IDLE : tmr_done ? LATCH : SETTLE;
            LATCH:   nxt = up ? CLEAR : HOLD;
            HOLD:    nxt = !tmr_done ? HOLD : run ? CLEAR : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // one timer serves the gate, the 2-cycle settle and the hold in turn
    always_comb begin
        tmr_start = state == CLEAR || (state == GATE && tmr_done) || (state == LATCH && !up);
        tmr_load = state == CLEAR ? TW'(gate_cycles(GATE_BASE, r) - 1) :
                   state == GATE  ? TW'(1) : TW'(HOLD_CYC - 1);
    end

    gate_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tmr_start),
        .load  (tmr_load),
        .done  (tmr_done)
    );

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r <= R_1S;
            cnt_clr <= 1'b0;
            cnt_en <= 1'b0;
            busy <= 1'b0;
            freq_valid <= 1'b0;
            freq <= '0;
            dp_pos <= R_1S;
            over <= 1'b0;
        end else begin
            state <= nxt;
            cnt_clr <= nxt == CLEAR;
            cnt_en <= nxt == GATE;
            busy <= nxt != IDLE;
            freq_valid <= state == LATCH && !up;
            if (nxt == CLEAR && !auto_en) r <= sel;
            else if (state == LATCH) r <= up ? r + 1'b1 : down ? r - 1'b1 : r;
            if (state == LATCH && !up) begin
                freq <= ovf ? FREQ_MAX : cnt_val;
                dp_pos <= r;
                over <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_frecuenciometro_ctrl.sv
// tb_frecuenciometro_ctrl: directed bench with a queue-fed counter model and gate-length monitor
module tb_frecuenciometro_ctrl;

    logic        clk = 1'b0, rst = 1'b1, run = 1'b0, auto_en = 1'b0;
    logic [1:0]  range_sel = 2'd0;
    logic [19:0] cnt_val = '0;
    logic        cnt_ovf = 1'b0;
    logic        cnt_clr, cnt_en, freq_valid, over, busy;
    logic [19:0] freq;
    logic [1:0]  dp_pos;

    int n_checks = 0, n_errors = 0;
    int en_run = 0, last_gate = 0, clr_run = 0, last_clr = 0, clr_cnt = 0, fv_cnt = 0;
    int fv0, c0;
    logic [20:0] q[$];

    frecuenciometro_ctrl #(.GATE_BASE(10), .HOLD_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .auto_en    (auto_en),
        .range_sel  (range_sel),
        .cnt_val    (cnt_val),
        .cnt_ovf    (cnt_ovf),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .freq       (freq),
        .dp_pos     (dp_pos),
        .freq_valid (freq_valid),
        .over       (over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // counter model: each clear pulse loads the next queued {ovf, value}
    always @(negedge clk) begin
        if (cnt_en) en_run++;
        else if (en_run > 0) begin
            last_gate = en_run;
            en_run = 0;
        end
        if (cnt_clr) begin
            clr_run++;
            if (clr_run == 1) begin
                clr_cnt++;
                if (q.size() > 0) {cnt_ovf, cnt_val} = q.pop_front();
            end
        end else if (clr_run > 0) begin
            last_clr = clr_run;
            clr_run = 0;
        end
        if (freq_valid) fv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = freq_valid;
        end
        check({tag, "_valid"}, 32'(seen), 1);
    endtask

    task automatic publish(input string tag, input int f, input int ov, input int dp, input int g);
        check({tag, "_freq"}, 32'(freq), f);
        check({tag, "_over"}, 32'(over), ov);
        check({tag, "_dp"}, 32'(dp_pos), dp);
        check({tag, "_gate"}, last_gate, g);
    endtask

    task automatic stop_run(input string tag, input int fv_exp, input int clr_exp);
        run = 1'b0;
        cycles(8);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_npub"}, fv_cnt - fv0, fv_exp);
        check({tag, "_nclr"}, clr_cnt - c0, clr_exp);
    endtask

    logic [1:0]  m_sel[3] = '{2'd2, 2'd3, 2'd1};
    logic [20:0] m_in[3]  = '{{1'b1, 20'd5}, {1'b0, 20'd999_999}, {1'b0, 20'd1_000_000}};
    int          m_ov[3]  = '{1, 0, 1};
    int          m_dp[3]  = '{2, 2, 1};
    int          m_g[3]   = '{10, 10, 100};

    initial begin
        cycles(2);
        check("rst_freq", 32'(freq), 0);
        check("rst_dp", 32'(dp_pos), 0);
        check("rst_over", 32'(over), 0);
        check("rst_valid", 32'(freq_valid), 0);
        check("rst_en", 32'(cnt_en), 0);
        check("rst_clr", 32'(cnt_clr), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        cycles(2);

        fv0 = fv_cnt; c0 = clr_cnt;
        q.push_back({1'b0, 20'd1234});
        run = 1'b1;
        wait_valid("man0", 1200);
        publish("man0", 1234, 0, 0, 1000);
        check("man0_clrw", last_clr, 1);
        cycles(1);
        check("man0_pulse", 32'(freq_valid), 0);
        stop_run("man0", 1, 1);

        fv0 = fv_cnt; c0 = clr_cnt;
        auto_en = 1'b1;
        q.push_back({1'b0, 20'd1_000_000});
        q.push_back({1'b0, 20'd200_000});
        run = 1'b1;
        wait_valid("up", 2500);
        publish("up", 200_000, 0, 1, 100);
        stop_run("up", 1, 2);

        fv0 = fv_cnt; c0 = clr_cnt;
        q.push_back({1'b0, 20'd5000});
        q.push_back({1'b0, 20'd300_000});
        run = 1'b1;
        wait_valid("dn", 400);
        publish("dn", 5000, 0, 1, 100);
        wait_valid("dn2", 1300);
        publish("dn2", 300_000, 0, 0, 1000);
        stop_run("dn", 2, 2);

        auto_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fv0 = fv_cnt; c0 = clr_cnt;
            range_sel = m_sel[i];
            q.push_back(m_in[i]);
            run = 1'b1;
            wait_valid("man", 300);
            publish("man", 999_999, m_ov[i], m_dp[i], m_g[i]);
            stop_run("man", 1, 1);
        end

        fv0 = fv_cnt; c0 = clr_cnt;
        range_sel = 2'd0;
        q.push_back({1'b0, 20'd4321});
        run = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = cnt_en;
            end
            check("abort_gate_start", 32'(seen), 1);
        end
        cycles(49);
        run = 1'b0;
        cycles(1);
        check("abort_en", 32'(cnt_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_freq", 32'(freq), 999_999);
        check("abort_over", 32'(over), 1);
        check("abort_dp", 32'(dp_pos), 1);
        cycles(5);
        check("abort_npub", fv_cnt - fv0, 0);

        q.push_back({1'b0, 20'd8888});
        run = 1'b1;
        wait_valid("hold", 1200);
        check("hold_freq", 32'(freq), 8888);
        cycles(1);
        rst = 1'b1;
        run = 1'b0;
        cycles(1);
        check("hrst_freq", 32'(freq), 0);
        check("hrst_over", 32'(over), 0);
        check("hrst_busy", 32'(busy), 0);
        check("hrst_en", 32'(cnt_en), 0);
        check("hrst_valid", 32'(freq_valid), 0);
        rst = 1'b0;
        cycles(6);
        check("hrst_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
